f8_bus_arbiter: RTL and testbench

Two-master arbiter that shares the f8 system's single-port synchronous RAM between the f8 CPU (master 0) and a DMA/debug loader (master 1). Each master uses a req/ack handshake. The arbiter issues at most one RAM access per cycle, using round-robin priority, and returns read data one cycle after issue. Out-of-range addresses are rejected with an error ack and never reach the RAM. The block sits inside `system`, between the masters and the RAM macro.

---
 rtl/f8_bus_arbiter_pkg.sv | 13 +
 rtl/f8_bus_arbiter_if.sv | 41 ++++
 rtl/f8_bus_arbiter_rr_pick2.sv | 23 ++
 rtl/f8_bus_arbiter.sv | 100 ++++++++++
 tb/tb_f8_bus_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/f8_bus_arbiter_pkg.sv
// Shared types and default widths for the f8 RAM arbiter.
// Master ids double as the round-robin "last" value.
package f8_arb_pkg;

    typedef logic [0:0] master_id_t;

    localparam master_id_t M_CPU = 1'b0;
    localparam master_id_t M_DMA = 1'b1;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

endpackage

// File: rtl/f8_bus_arbiter_if.sv
// Bundle of both master handshakes and the RAM port seen by the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's.
interface f8_bus_arbiter_if #(
    parameter int unsigned ADDR_W = f8_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W = f8_arb_pkg::DATA_W
);
    logic              m0_req;
    logic              m1_req;
    logic              m0_we;
    logic              m1_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m1_wdata;
    logic              m0_ack;
    logic              m1_ack;
    logic              m0_err;
    logic              m1_err;
    logic [DATA_W-1:0] m0_rdata;
    logic [DATA_W-1:0] m1_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  mem_rdata,
        output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        output mem_rdata,
        input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/f8_bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester that was
// not granted most recently wins.
module rr_pick2
    import f8_arb_pkg::*;
(
    input  logic [1:0] i_elig,
    input  master_id_t i_last,
    output logic       o_grant_valid,
    output master_id_t o_grant_id
);

    always_comb begin
        o_grant_valid = |i_elig;
        o_grant_id    = M_CPU;
        case (i_elig)
            2'b01:   o_grant_id = M_CPU;
            2'b10:   o_grant_id = M_DMA;
            2'b11:   o_grant_id = ~i_last;
            default: o_grant_id = M_CPU;
        endcase
    end

endmodule

// File: rtl/f8_bus_arbiter.sv
// Shares the single-port f8 RAM between the CPU (master 0) and the DMA/debug
// loader (master 1); one access per cycle, acks registered one cycle later.
module f8_bus_arbiter
    import f8_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = f8_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W   = f8_arb_pkg::DATA_W,
    parameter int unsigned MEM_SIZE = 2048
) (
    input  logic             clk,
    input  logic             reset,
    f8_bus_arbiter_if.slave  bus
);

    localparam logic [ADDR_W:0] MEM_LIMIT = MEM_SIZE[ADDR_W:0];

    logic [1:0]        w_elig;
    logic              w_gvalid;
    master_id_t        w_gid;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_oor;
    logic              w_mem_go;
    logic              w_ack0;
    logic              w_ack1;
    logic              w_rd_ok;

    master_id_t        r_last;
    logic              r_pend;
    master_id_t        r_pend_id;
    logic              r_pend_err;
    logic              r_pend_rd;

    // A master whose access was issued last cycle waits out its ack.
    assign w_elig[0] = bus.m0_req & ~(r_pend & (r_pend_id == M_CPU));
    assign w_elig[1] = bus.m1_req & ~(r_pend & (r_pend_id == M_DMA));

    rr_pick2 u_pick (
        .i_elig        (w_elig),
        .i_last        (r_last),
        .o_grant_valid (w_gvalid),
        .o_grant_id    (w_gid)
    );

    always_comb begin
        w_we    = bus.m0_we;
        w_addr  = bus.m0_addr;
        w_wdata = bus.m0_wdata;
        if (w_gid == M_DMA) begin
            w_we    = bus.m1_we;
            w_addr  = bus.m1_addr;
            w_wdata = bus.m1_wdata;
        end
    end

    assign w_oor    = {1'b0, w_addr} >= MEM_LIMIT;
    // Reset gating keeps a write presented during reset off the RAM.
    assign w_mem_go = w_gvalid & ~w_oor & ~reset;

    always_comb begin
        bus.mem_en    = w_mem_go;
        bus.mem_we    = w_mem_go & w_we;
        bus.mem_addr  = w_mem_go ? w_addr : '0;
        bus.mem_wdata = w_mem_go ? w_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last     <= M_DMA;
            r_pend     <= 1'b0;
            r_pend_id  <= M_CPU;
            r_pend_err <= 1'b0;
            r_pend_rd  <= 1'b0;
        end else begin
            r_pend <= w_gvalid;
            if (w_gvalid) begin
                r_last     <= w_gid;
                r_pend_id  <= w_gid;
                r_pend_err <= w_oor;
                r_pend_rd  <= ~w_we;
            end
        end
    end

    // Pending ack is dropped while reset is high so none escapes the reset cycle.
    assign w_ack0  = r_pend & ~reset & (r_pend_id == M_CPU);
    assign w_ack1  = r_pend & ~reset & (r_pend_id == M_DMA);
    assign w_rd_ok = r_pend_rd & ~r_pend_err;

    always_comb begin
        bus.m0_ack   = w_ack0;
        bus.m1_ack   = w_ack1;
        bus.m0_err   = w_ack0 & r_pend_err;
        bus.m1_err   = w_ack1 & r_pend_err;
        bus.m0_rdata = (w_ack0 & w_rd_ok) ? bus.mem_rdata : '0;
        bus.m1_rdata = (w_ack1 & w_rd_ok) ? bus.mem_rdata : '0;
    end

endmodule

// File: tb/tb_f8_bus_arbiter.sv
// Bench for f8_bus_arbiter: vector table, directed corner sequences and a
// randomized run against a rule-level reference model with a RAM behind it.
module tb_f8_bus_arbiter;
    import f8_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    f8_bus_arbiter_if bus ();

    f8_bus_arbiter #(
        .ADDR_W   (16),
        .DATA_W   (8),
        .MEM_SIZE (2048)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM macro model: synchronous, read data valid the cycle after mem_en.
    logic [7:0] ram [0:2047];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr[10:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr[10:0]];
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [63:0] memv(input logic en, input logic we,
                                         input logic [15:0] a, input logic [7:0] d);
        return {38'd0, en, we, a, d};
    endfunction

    function automatic logic [63:0] ackv(input logic a0, input logic e0, input logic [7:0] r0,
                                         input logic a1, input logic e1, input logic [7:0] r1);
        return {44'd0, a0, e0, r0, a1, e1, r1};
    endfunction

    function automatic logic [63:0] dut_mem();
        return memv(bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    endfunction

    function automatic logic [63:0] dut_ack();
        return ackv(bus.m0_ack, bus.m0_err, bus.m0_rdata, bus.m1_ack, bus.m1_err, bus.m1_rdata);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic rq, input logic we,
                         input logic [15:0] a, input logic [7:0] d);
        if (m == 0) begin
            bus.m0_req = rq; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_req = rq; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        tick();
        @(negedge clk);
        check("reset_mem", dut_mem(), memv(1'b0, 1'b0, 16'h0, 8'h0));
        check("reset_ack", dut_ack(), ackv(1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 8'h0));
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        int         m;
        logic       we;
        logic [15:0] addr;
        logic [7:0] wdata;
        logic       exp_en;
        logic       exp_err;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t tbl [7];

    // Reference model state: rule-level view of who may issue and what is owed.
    bit         iss_prev [2];
    bit         m_last;
    bit         due      [2];
    bit         due_err  [2];
    logic [7:0] due_rd   [2];
    logic [7:0] shadow   [32];
    logic       rq  [2];
    logic       rwe [2];
    logic [15:0] raddr [2];
    logic [7:0] rwd [2];

    task automatic model_step();
        bit         elig [2];
        int         win;
        bit         issue, oor, go;
        logic [15:0] a;
        logic [63:0] exp_m;
        elig[0] = rq[0] && !iss_prev[0];
        elig[1] = rq[1] && !iss_prev[1];
        issue = elig[0] || elig[1];
        if (elig[0] && elig[1]) win = m_last ? 0 : 1;
        else                    win = elig[1] ? 1 : 0;
        a   = raddr[win];
        oor = a >= 16'd2048;
        go  = issue && !oor;
        exp_m = go ? memv(1'b1, rwe[win], a, rwd[win]) : memv(1'b0, 1'b0, 16'h0, 8'h0);
        check("rand_mem", dut_mem(), exp_m);
        check("rand_ack", dut_ack(), ackv(due[0], due[0] && due_err[0], due[0] ? due_rd[0] : 8'h0,
                                          due[1], due[1] && due_err[1], due[1] ? due_rd[1] : 8'h0));
        iss_prev[0] = 0; iss_prev[1] = 0;
        due[0] = 0; due[1] = 0;
        if (issue) begin
            iss_prev[win] = 1;
            m_last        = (win == 1);
            due[win]      = 1;
            due_err[win]  = oor;
            due_rd[win]   = (!rwe[win] && !oor) ? shadow[a[4:0]] : 8'h0;
            if (go && rwe[win]) shadow[a[4:0]] = rwd[win];
        end
    endtask

    function automatic logic [15:0] rand_addr();
        int sel = $urandom_range(0, 9);
        if (sel < 7) return 16'($urandom_range(0, 31));
        if (sel == 7) return 16'h0800;
        if (sel == 8) return 16'h0FFF;
        return 16'hFFFF;
    endfunction

    initial begin
        int         c [2];
        int         w;
        logic [15:0] a;
        logic [7:0] d;

        tbl[0] = '{0, 1'b1, 16'h0010, 8'h5A, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{0, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b0, 8'h5A};
        tbl[2] = '{1, 1'b1, 16'h07FF, 8'hC3, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{1, 1'b0, 16'h07FF, 8'h00, 1'b1, 1'b0, 8'hC3};
        tbl[4] = '{0, 1'b1, 16'h0800, 8'hEE, 1'b0, 1'b1, 8'h00};
        tbl[5] = '{1, 1'b0, 16'hFFFF, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[6] = '{0, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b0, 8'h5A};

        do_reset();

        foreach (tbl[i]) begin
            tick();
            drive(tbl[i].m, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            @(negedge clk);
            check("vec_issue", dut_mem(), tbl[i].exp_en ?
                  memv(1'b1, tbl[i].we, tbl[i].addr, tbl[i].we ? tbl[i].wdata : 8'h0) :
                  memv(1'b0, 1'b0, 16'h0, 8'h0));
            tick();
            drive(tbl[i].m, 1'b0, 1'b0, 16'h0, 8'h0);
            @(negedge clk);
            if (tbl[i].m == 0)
                check("vec_ack", dut_ack(), ackv(1'b1, tbl[i].exp_err, tbl[i].exp_rdata,
                                                 1'b0, 1'b0, 8'h0));
            else
                check("vec_ack", dut_ack(), ackv(1'b0, 1'b0, 8'h0,
                                                 1'b1, tbl[i].exp_err, tbl[i].exp_rdata));
        end

        // Contention: continuous writes from both, alternating from m0.
        do_reset();
        c[0] = 0; c[1] = 0;
        drive(0, 1'b1, 1'b1, 16'h0020, 8'h20 ^ 8'h05);
        drive(1, 1'b1, 1'b1, 16'h0040, 8'h40 ^ 8'h05);
        for (int i = 0; i < 8; i++) begin
            w = i % 2;
            a = (w == 1) ? 16'(16'h0040 + c[1]) : 16'(16'h0020 + c[0]);
            @(negedge clk);
            check("cont_issue", dut_mem(), memv(1'b1, 1'b1, a, a[7:0] ^ 8'h05));
            if (i == 0)     check("cont_ack", dut_ack(), ackv(0, 0, 8'h0, 0, 0, 8'h0));
            else if (w == 1) check("cont_ack", dut_ack(), ackv(1, 0, 8'h0, 0, 0, 8'h0));
            else             check("cont_ack", dut_ack(), ackv(0, 0, 8'h0, 1, 0, 8'h0));
            c[w]++;
            tick();
            a = (w == 1) ? 16'(16'h0040 + c[1]) : 16'(16'h0020 + c[0]);
            drive(w, 1'b1, 1'b1, a, a[7:0] ^ 8'h05);
        end
        drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
        @(negedge clk);
        check("cont_last_ack", dut_ack(), ackv(0, 0, 8'h0, 1, 0, 8'h0));
        tick();

        // Single master back-to-back: issue every other cycle.
        drive(1, 1'b1, 1'b0, 16'h0040, 8'h0);
        for (int j = 0; j < 8; j++) begin
            a = 16'(16'h0040 + j / 2);
            @(negedge clk);
            if (j % 2 == 0) begin
                check("b2b_issue", dut_mem(), memv(1'b1, 1'b0, a, 8'h0));
                check("b2b_noack", dut_ack(), ackv(0, 0, 8'h0, 0, 0, 8'h0));
            end else begin
                check("b2b_idle", dut_mem(), memv(1'b0, 1'b0, 16'h0, 8'h0));
                check("b2b_ack", dut_ack(), ackv(0, 0, 8'h0, 1, 0, a[7:0] ^ 8'h05));
            end
            tick();
            if (j % 2 == 1) drive(1, j < 7, 1'b0, 16'(a + 1), 8'h0);
        end

        // Reset mid-access: m1 read issued, reset next cycle with an m0 write.
        drive(1, 1'b1, 1'b0, 16'h0041, 8'h0);
        @(negedge clk);
        check("rst_issue", dut_mem(), memv(1'b1, 1'b0, 16'h0041, 8'h0));
        tick();
        reset = 1'b1;
        drive(0, 1'b1, 1'b1, 16'h0030, 8'h77);
        @(negedge clk);
        check("rst_mem_off", dut_mem(), memv(1'b0, 1'b0, 16'h0, 8'h0));
        check("rst_no_ack", dut_ack(), ackv(0, 0, 8'h0, 0, 0, 8'h0));
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_tie_m0", dut_mem(), memv(1'b1, 1'b1, 16'h0030, 8'h77));
        check("rst_still_no_ack", dut_ack(), ackv(0, 0, 8'h0, 0, 0, 8'h0));
        tick();
        drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
        @(negedge clk);
        check("rst_m1_next", dut_mem(), memv(1'b1, 1'b0, 16'h0041, 8'h0));
        check("rst_m0_ack", dut_ack(), ackv(1, 0, 8'h0, 0, 0, 8'h0));
        tick();
        drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
        @(negedge clk);
        check("rst_m1_ack", dut_ack(), ackv(0, 0, 8'h0, 1, 0, 8'h41 ^ 8'h05));
        tick();

        // Tie after history: m1 issued last, so m0 wins the next tie.
        drive(1, 1'b1, 1'b1, 16'h0050, 8'h11);
        tick();
        drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        drive(0, 1'b1, 1'b0, 16'h0030, 8'h0);
        drive(1, 1'b1, 1'b1, 16'h0051, 8'h22);
        @(negedge clk);
        check("hist_tie_m0", dut_mem(), memv(1'b1, 1'b0, 16'h0030, 8'h0));
        tick();
        drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
        @(negedge clk);
        check("hist_m1", dut_mem(), memv(1'b1, 1'b1, 16'h0051, 8'h22));
        check("hist_m0_ack", dut_ack(), ackv(1, 0, 8'h77, 0, 0, 8'h0));
        tick();
        drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
        @(negedge clk);
        check("hist_m1_ack", dut_ack(), ackv(0, 0, 8'h0, 1, 0, 8'h0));
        tick();

        // Known RAM contents for the random run.
        for (int k = 0; k < 32; k++) begin
            drive(0, 1'b1, 1'b1, 16'(k), 8'(k) ^ 8'hA5);
            tick();
            drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
            tick();
            shadow[k] = 8'(k) ^ 8'hA5;
        end

        do_reset();
        for (int m = 0; m < 2; m++) begin
            iss_prev[m] = 0; due[m] = 0; due_err[m] = 0; due_rd[m] = 8'h0;
            rq[m] = 0; rwe[m] = 0; raddr[m] = 16'h0; rwd[m] = 8'h0;
        end
        m_last = 1;
        for (int n = 0; n < 600; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (!rq[m] || due[m]) begin
                    rq[m] = ($urandom_range(0, 9) < 7);
                    rwe[m] = $urandom_range(0, 1) == 1;
                    raddr[m] = rand_addr();
                    d = 8'($urandom);
                    rwd[m] = d;
                end
                drive(m, rq[m], rwe[m], raddr[m], rwd[m]);
            end
            @(negedge clk);
            model_step();
            tick();
        end
        drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 8'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
